// File: rtl/checkout_payment.sv
// ============================================================================
//  Module      : checkout_payment
//  Description : Checkout payment controller. Latches a bill, collects coins,
//                then pays change or a full refund one coin at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module checkout_payment #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Pay,
  input  logic [W-1:0] Bill,
  input  logic         Coin_Valid,
  input  logic [1:0]   Coin_Sel,
  input  logic         Cancel,
  input  logic         Hopper_Ready,
  output logic         Coin_Out_Valid,
  output logic [1:0]   Coin_Out_Sel,
  output logic [W-1:0] Due,
  output logic [W:0]   Paid,
  output logic         Busy,
  output logic         Refunding,
  output logic         Coin_Reject,
  output logic         Done,
  output logic         Cancelled
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PAYOUT  = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] bill_q, bill_d;
  logic [W-1:0] due_q, due_d;
  logic [W:0]   paid_q, paid_d;
  logic [W:0]   change_q, change_d;
  logic         refund_q, refund_d;
  logic         reject_q, reject_d;
  logic         done_q, done_d;
  logic         cancel_q, cancel_d;

  logic [W:0]   paid_sum;
  logic [W:0]   paid_new;
  logic         covered;
  logic [1:0]   out_sel;

  function automatic logic [W:0] denom(input logic [1:0] sel);
    case (sel)
      2'b00:   denom = (W+1)'(1);
      2'b01:   denom = (W+1)'(2);
      2'b10:   denom = (W+1)'(5);
      default: denom = (W+1)'(10);
    endcase
  endfunction

  // Greedy change selection over 10/5/2/1 gives the fewest coins.
  always_comb begin
    if (change_q >= (W+1)'(10))     out_sel = 2'b11;
    else if (change_q >= (W+1)'(5)) out_sel = 2'b10;
    else if (change_q >= (W+1)'(2)) out_sel = 2'b01;
    else                            out_sel = 2'b00;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      bill_q   <= '0;
      due_q    <= '0;
      paid_q   <= '0;
      change_q <= '0;
      refund_q <= 1'b0;
      reject_q <= 1'b0;
      done_q   <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bill_q   <= bill_d;
      due_q    <= due_d;
      paid_q   <= paid_d;
      change_q <= change_d;
      refund_q <= refund_d;
      reject_q <= reject_d;
      done_q   <= done_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bill_d   = bill_q;
    due_d    = due_q;
    paid_d   = paid_q;
    change_d = change_q;
    refund_d = refund_q;
    reject_d = 1'b0;
    done_d   = 1'b0;
    cancel_d = 1'b0;
    paid_sum = paid_q + denom(Coin_Sel);
    paid_new = Coin_Valid ? paid_sum : paid_q;
    covered  = (paid_sum >= {1'b0, bill_q});

    case (state_q)
      S_IDLE: begin
        reject_d = Coin_Valid;
        if (Pay) begin
          if (Bill != '0) begin
            bill_d   = Bill;
            due_d    = Bill;
            paid_d   = '0;
            refund_d = 1'b0;
            state_d  = S_COLLECT;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (Coin_Valid) begin
          paid_d = paid_sum;
          due_d  = covered ? '0 : bill_q - paid_sum[W-1:0];
        end
        // A coin arriving with Cancel is counted, then refunded with the rest.
        if (Cancel) begin
          if (paid_new == '0) begin
            cancel_d = 1'b1;
            due_d    = '0;
            state_d  = S_IDLE;
          end else begin
            change_d = paid_new;
            refund_d = 1'b1;
            state_d  = S_PAYOUT;
          end
        end else if (Coin_Valid && covered) begin
          change_d = paid_sum - {1'b0, bill_q};
          state_d  = S_PAYOUT;
        end
      end

      S_PAYOUT: begin
        reject_d = Coin_Valid;
        if (change_q == '0) begin
          state_d = S_FINISH;
        end else if (Hopper_Ready) begin
          change_d = change_q - denom(out_sel);
        end
      end

      S_FINISH: begin
        reject_d = Coin_Valid;
        paid_d   = '0;
        due_d    = '0;
        refund_d = 1'b0;
        change_d = '0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign Coin_Out_Valid = (state_q == S_PAYOUT) && (change_q != '0);
  assign Coin_Out_Sel   = (state_q == S_PAYOUT) ? out_sel : 2'b00;
  assign Due            = due_q;
  assign Paid           = paid_q;
  assign Busy           = (state_q != S_IDLE);
  assign Refunding      = refund_q;
  assign Coin_Reject    = reject_q;
  assign Done           = ((state_q == S_FINISH) && !refund_q) || done_q;
  assign Cancelled      = ((state_q == S_FINISH) && refund_q) || cancel_q;

endmodule

`default_nettype wire

// File: tb/tb_checkout_payment.sv
// ============================================================================
//  Module      : tb_checkout_payment
//  Description : Self-checking bench for checkout_payment (table + random).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_checkout_payment;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pay = 1'b0;
  logic [W-1:0] bill = '0;
  logic         coin_valid = 1'b0;
  logic [1:0]   coin_sel = 2'b00;
  logic         cancel = 1'b0;
  logic         hopper_ready = 1'b0;
  logic         coin_out_valid;
  logic [1:0]   coin_out_sel;
  logic [W-1:0] due;
  logic [W:0]   paid;
  logic         busy, refunding, coin_reject, done, cancelled;

  int n_cmp = 0;
  int n_err = 0;

  typedef int iq_t[$];

  typedef struct {
    int bill;
    int n;
    int coins[4];
    int cancel_idx;
    int exp_cancel;
    int nout;
    int outs[4];
  } vec_t;

  vec_t tbl[8];

  checkout_payment #(.W(W)) dut (
    .Clk(clk), .Reset(reset), .Pay(pay), .Bill(bill),
    .Coin_Valid(coin_valid), .Coin_Sel(coin_sel), .Cancel(cancel),
    .Hopper_Ready(hopper_ready), .Coin_Out_Valid(coin_out_valid),
    .Coin_Out_Sel(coin_out_sel), .Due(due), .Paid(paid), .Busy(busy),
    .Refunding(refunding), .Coin_Reject(coin_reject), .Done(done),
    .Cancelled(cancelled)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(input int v);
    case (v)
      1:       return 2'b00;
      2:       return 2'b01;
      5:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic int sel2val(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 10;
    endcase
  endfunction

  // Fewest-coins decomposition by counting each denomination.
  function automatic iq_t fewest(input int amount);
    iq_t q;
    int r;
    int n10, n5, n2, n1;
    n10 = amount / 10;
    r   = amount % 10;
    n5  = r / 5;
    r   = r % 5;
    n2  = r / 2;
    n1  = r % 2;
    for (int i = 0; i < n10; i++) q.push_back(10);
    for (int i = 0; i < n5; i++)  q.push_back(5);
    for (int i = 0; i < n2; i++)  q.push_back(2);
    for (int i = 0; i < n1; i++)  q.push_back(1);
    return q;
  endfunction

  task automatic set_vec(input int i, input int b, input int n,
                         input int c0, input int c1, input int c2, input int c3,
                         input int ci, input int ec, input int no,
                         input int o0, input int o1, input int o2, input int o3);
    tbl[i].bill = b;
    tbl[i].n = n;
    tbl[i].coins[0] = c0; tbl[i].coins[1] = c1;
    tbl[i].coins[2] = c2; tbl[i].coins[3] = c3;
    tbl[i].cancel_idx = ci;
    tbl[i].exp_cancel = ec;
    tbl[i].nout = no;
    tbl[i].outs[0] = o0; tbl[i].outs[1] = o1;
    tbl[i].outs[2] = o2; tbl[i].outs[3] = o3;
  endtask

  // Services the hopper until the transaction ends, then checks the coins out.
  task automatic drain(input int exp_cancel, input iq_t exp_q, input int ready_pct,
                       output int steps);
    iq_t got;
    bit  fin = 1'b0;
    bit  prev_hold = 1'b0;
    int  prev_sel = 0;
    steps = 0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (done || cancelled) begin
        fin = 1'b1;
        check("done_flag", int'(done), (exp_cancel == 0) ? 1 : 0);
        check("cancelled_flag", int'(cancelled), exp_cancel);
      end else begin
        if (prev_hold) begin
          check("hold_valid", int'(coin_out_valid), 1);
          check("hold_sel", int'(coin_out_sel), prev_sel);
        end
        if (coin_out_valid) check("refunding", int'(refunding), exp_cancel);
        hopper_ready = ($urandom_range(99) < ready_pct);
        if (coin_out_valid && hopper_ready) got.push_back(sel2val(coin_out_sel));
        prev_hold = coin_out_valid && !hopper_ready;
        prev_sel  = int'(coin_out_sel);
        step();
        steps++;
      end
    end
    if (!fin) check("payout_timeout", 0, 1);
    hopper_ready = 1'b0;
    check("n_coins_out", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check("coin_out", got[i], exp_q[i]);
    step();
    check("idle_busy", int'(busy), 0);
    check("idle_paid", int'(paid), 0);
    check("idle_done", int'(done), 0);
    check("idle_cancelled", int'(cancelled), 0);
  endtask

  // Runs one transaction; cancel_idx == coins.size() means Cancel alone after all coins.
  task automatic run_txn(input int b, input iq_t coins, input int cancel_idx,
                         input int exp_cancel, input iq_t exp_q, input int ready_pct,
                         output int steps);
    int sum = 0;
    pay = 1'b1;
    bill = W'(b);
    step();
    pay = 1'b0;
    check("collect_busy", int'(busy), 1);
    check("collect_due", int'(due), b);
    check("collect_paid", int'(paid), 0);
    for (int i = 0; i < coins.size(); i++) begin
      coin_valid = 1'b1;
      coin_sel   = enc(coins[i]);
      cancel     = (i == cancel_idx);
      step();
      coin_valid = 1'b0;
      cancel     = 1'b0;
      sum += coins[i];
      check("paid", int'(paid), sum);
      check("due", int'(due), (sum >= b) ? 0 : b - sum);
      check("no_reject", int'(coin_reject), 0);
      if (sum >= b || i == cancel_idx) break;
    end
    if (cancel_idx == coins.size()) begin
      cancel = 1'b1;
      step();
      cancel = 1'b0;
    end
    drain(exp_cancel, exp_q, ready_pct, steps);
  endtask

  initial begin
    iq_t coins, expq;
    int  steps;
    int  b, total, cidx, ecan;

    set_vec(0, 17, 3, 10, 5, 2, 0, -1, 0, 0, 0, 0, 0, 0);
    set_vec(1, 13, 2, 10, 10, 0, 0, -1, 0, 2, 5, 2, 0, 0);
    set_vec(2, 20, 3, 10, 5, 2, 0, 2, 1, 3, 10, 5, 2, 0);
    set_vec(3, 1, 1, 10, 0, 0, 0, -1, 0, 3, 5, 2, 2, 0);
    set_vec(4, 255, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    set_vec(5, 4, 3, 1, 1, 2, 0, -1, 0, 0, 0, 0, 0, 0);
    set_vec(6, 30, 2, 10, 10, 0, 0, 1, 1, 2, 10, 10, 0, 0);
    set_vec(7, 6, 4, 2, 2, 1, 2, -1, 0, 1, 1, 0, 0, 0);

    step();
    step();
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(coin_out_valid), 0);
    check("rst_paid", int'(paid), 0);
    check("rst_due", int'(due), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    step();

    // Directed table
    for (int t = 0; t < 8; t++) begin
      coins.delete();
      expq.delete();
      for (int i = 0; i < tbl[t].n; i++) coins.push_back(tbl[t].coins[i]);
      for (int i = 0; i < tbl[t].nout; i++) expq.push_back(tbl[t].outs[i]);
      run_txn(tbl[t].bill, coins, tbl[t].cancel_idx, tbl[t].exp_cancel, expq, 100, steps);
      if (tbl[t].nout == 0 && tbl[t].exp_cancel == 0)
        check("done_latency", steps, 1);
    end

    // Coin in IDLE is rejected and not counted
    coin_valid = 1'b1; coin_sel = 2'b11;
    step();
    coin_valid = 1'b0;
    check("idle_reject", int'(coin_reject), 1);
    check("idle_reject_paid", int'(paid), 0);
    step();
    check("idle_reject_pulse", int'(coin_reject), 0);

    // Zero bill completes at once without becoming busy
    pay = 1'b1; bill = '0;
    step();
    pay = 1'b0;
    check("zero_bill_done", int'(done), 1);
    check("zero_bill_busy", int'(busy), 0);
    step();
    check("zero_bill_pulse", int'(done), 0);

    // Second Pay during COLLECT is ignored: change must come from bill 9
    pay = 1'b1; bill = 8'd9;
    step();
    bill = 8'd3;
    step();
    pay = 1'b0;
    check("repay_due", int'(due), 9);
    coin_valid = 1'b1; coin_sel = 2'b11;
    step();
    coin_valid = 1'b0;
    expq = fewest(1);
    drain(0, expq, 100, steps);

    // Change of 9 held while the hopper stalls; a coin offered meanwhile is rejected
    pay = 1'b1; bill = 8'd1;
    step();
    pay = 1'b0;
    coin_valid = 1'b1; coin_sel = 2'b11;
    step();
    coin_valid = 1'b0;
    hopper_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("stall_valid", int'(coin_out_valid), 1);
      check("stall_sel", int'(coin_out_sel), 2);
      coin_valid = (k == 1);
      coin_sel = 2'b00;
      step();
      coin_valid = 1'b0;
      if (k == 1) begin
        check("payout_reject", int'(coin_reject), 1);
        check("payout_reject_paid", int'(paid), 10);
      end
    end
    expq.delete();
    expq.push_back(5); expq.push_back(2); expq.push_back(2);
    drain(0, expq, 100, steps);

    // Asynchronous reset in the middle of a payout
    pay = 1'b1; bill = 8'd1;
    step();
    pay = 1'b0;
    coin_valid = 1'b1; coin_sel = 2'b11;
    step();
    coin_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_out_valid", int'(coin_out_valid), 0);
    check("arst_paid", int'(paid), 0);
    check("arst_due", int'(due), 0);
    check("arst_refunding", int'(refunding), 0);
    check("arst_done", int'(done), 0);
    #1 reset = 1'b0;
    coins.delete(); coins.push_back(5);
    expq.delete();
    run_txn(5, coins, -1, 0, expq, 100, steps);

    // Randomized transactions against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      b = ($urandom_range(3) == 0) ? int'($urandom_range(255, 200)) : int'($urandom_range(60, 1));
      coins.delete();
      total = 0;
      while (total < b) begin
        case ($urandom_range(3))
          0:       coins.push_back(1);
          1:       coins.push_back(2);
          2:       coins.push_back(5);
          default: coins.push_back(10);
        endcase
        total += coins[coins.size()-1];
      end
      cidx = -1;
      ecan = 0;
      if ($urandom_range(3) == 0) begin
        ecan = 1;
        cidx = int'($urandom_range(coins.size() - 1));
        if ($urandom_range(1) == 0)
          while (coins.size() > cidx) void'(coins.pop_back());
      end
      total = 0;
      for (int i = 0; i < coins.size(); i++)
        if (cidx < 0 || i <= cidx) total += coins[i];
      expq = ecan ? fewest(total) : fewest(total - b);
      run_txn(b, coins, cidx, ecan, expq, int'($urandom_range(90, 30)), steps);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
